// File: rtl/bcedn_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcedn_sched_pkg
// Brief   : Shared state encoding and counter-width helpers for the BCEDN
//           frame scheduler.
// Revision: 1.0
// ============================================================================
package bcedn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FEED  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

  // Width of a counter holding values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Widths for the default 32x32 frame, 1-cycle gap, 1024-beat drain.
  localparam int unsigned ROW_W = cnt_w(32);
  localparam int unsigned COL_W = cnt_w(32);
  localparam int unsigned GAP_W = cnt_w(1 + 1);
  localparam int unsigned OUT_W = cnt_w(1024 + 1);

endpackage
`default_nettype wire

// File: rtl/bcedn_sched_skid.sv
`default_nettype none
// ============================================================================
// Module  : bcedn_sched_skid
// Brief   : One-entry hold register that parks a returning read beat while
//           the encoder-decoder is inserting padding.
// Revision: 1.0
// ============================================================================
module bcedn_sched_skid #(
  parameter int unsigned D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_valid,
  input  logic [D-1:0] rd_data,
  input  logic         pad_busy,
  output logic         in_en,
  output logic [D-1:0] data_in,
  output logic         hold_free,
  output logic         held
);

  logic         hold_v_q, hold_v_d;
  logic [D-1:0] hold_q, hold_d;
  logic [D-1:0] beat;

  always_comb begin
    hold_v_d = hold_v_q ? pad_busy : (rd_valid & pad_busy);
    hold_d   = hold_q;
    if (!hold_v_q && rd_valid && pad_busy) begin
      hold_d = rd_data;
    end
  end

  // The stall is combinational in pad_busy; a held beat always wins.
  assign beat      = hold_v_q ? hold_q : rd_data;
  assign in_en     = (hold_v_q | rd_valid) & ~pad_busy;
  assign data_in   = in_en ? beat : '0;
  assign hold_free = ~hold_v_d;
  assign held      = hold_v_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcedn_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : bcedn_frame_scheduler
// Brief   : Streams one HxW frame into BCEDN_ENDECODER and waits for N_OUT
//           output beats. Optional drain watchdog: BCEDN_SCHED_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module bcedn_frame_scheduler
  import bcedn_sched_pkg::*;
#(
  parameter int unsigned H           = 32,
  parameter int unsigned W           = 32,
  parameter int unsigned D           = 8,
  parameter int unsigned P           = 1,
  parameter int unsigned N_OUT       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [D-1:0]      mem_rdata,
  input  logic              pad_busy,
  output logic              edc_start,
  output logic              in_en,
  output logic [D-1:0]      data_in,
  input  logic              out_en,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned ROW_BITS = cnt_w(H);
  localparam int unsigned COL_BITS = cnt_w(W);
  localparam int unsigned GAP_BITS = cnt_w(P + 1);
  localparam int unsigned OUT_BITS = cnt_w(N_OUT + 1);

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(H - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(W - 1);
  localparam logic [GAP_BITS-1:0] GAP_LAST = GAP_BITS'(P - 1);
  localparam logic [OUT_BITS-1:0] OUT_LAST = OUT_BITS'(N_OUT);

  sched_state_e        state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic [OUT_BITS-1:0] out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                edc_start_q, edc_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_issue, hold_free, held;

`ifdef BCEDN_SCHED_TIMEOUT_EN
  localparam int unsigned WD_BITS = cnt_w(TIMEOUT_CYC);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYC - 1);
  logic [WD_BITS-1:0] wd_q, wd_d;
  logic               timeout_q, timeout_d;
`endif

  // A read is only launched when its return slot is guaranteed free.
  assign rd_issue = (state_q == FEED) & ~pad_busy & hold_free;
  assign mem_rd   = rd_issue;
  assign mem_addr = rd_issue ? next_addr_q : last_addr_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    gap_d       = gap_q;
    out_cnt_d   = out_cnt_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    rd_pend_d   = rd_issue;
`ifdef BCEDN_SCHED_TIMEOUT_EN
    timeout_d = timeout_q;
    wd_d      = '0;
`endif

    if ((state_q == FEED || state_q == GAP || state_q == DRAIN) &&
        out_en && out_cnt_q != OUT_LAST) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d     = START;
          row_d       = '0;
          col_d       = '0;
          gap_d       = '0;
          out_cnt_d   = '0;
          next_addr_d = '0;
`ifdef BCEDN_SCHED_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      START: state_d = FEED;
      FEED: begin
        if (rd_issue) begin
          last_addr_d = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              state_d = DRAIN;
            end else if (P > 0) begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = FEED;
        else                   gap_d   = gap_q + 1'b1;
      end
      DRAIN: begin
        if (!rd_pend_q && !held && out_cnt_q == OUT_LAST) begin
          state_d = DONE;
        end
`ifdef BCEDN_SCHED_TIMEOUT_EN
        else if (!out_en) begin
          if (wd_q == WD_LAST) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    edc_start_d = (state_d == START);
    busy_d      = (state_d == START) || (state_d == FEED) ||
                  (state_d == GAP)   || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      gap_q       <= '0;
      out_cnt_q   <= '0;
      next_addr_q <= '0;
      last_addr_q <= '0;
      rd_pend_q   <= 1'b0;
      edc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BCEDN_SCHED_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      gap_q       <= gap_d;
      out_cnt_q   <= out_cnt_d;
      next_addr_q <= next_addr_d;
      last_addr_q <= last_addr_d;
      rd_pend_q   <= rd_pend_d;
      edc_start_q <= edc_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BCEDN_SCHED_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign edc_start = edc_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef BCEDN_SCHED_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  bcedn_sched_skid #(
    .D (D)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .rd_valid  (rd_pend_q),
    .rd_data   (mem_rdata),
    .pad_busy  (pad_busy),
    .in_en     (in_en),
    .data_in   (data_in),
    .hold_free (hold_free),
    .held      (held)
  );

endmodule
`default_nettype wire

// File: doc/bcedn_frame_scheduler.md
Name: bcedn_frame_scheduler

Overview:
- Sequences one frame through the BCEDN encoder-decoder:
  - issues the `start` pulse;
  - raster-reads H×W pixel vectors from an input frame buffer and drives the in_en/data_in stream;
  - inserts inter-row gap cycles;
  - honours the pad-insertion stall from the encoder-decoder controller;
  - counts out_en beats until the frame is drained.
- Sits between the host/frame-buffer side and the BCEDN_ENDECODER top. It replaces file-driven stimulus in system integration.

Parameters:
- H, 32, input frame rows.
- W, 32, input frame columns.
- D, 8, pixel vector width (bits).
- P, 1, idle cycles inserted after each completed row; 0 means no gap.
- N_OUT, 1024, number of out_en beats that complete one frame.
- ADDR_W, 10, frame-buffer address width; must be ≥ clog2(H*W).
- TIMEOUT_CYC, 4096, drain watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- go  in  1  1-cycle request to process one frame; ignored unless IDLE
- mem_rd  out  1  frame-buffer read strobe
- mem_addr  out  ADDR_W  read address, row*W+col
- mem_rdata  in  D  read data, valid exactly 1 cycle after mem_rd
- pad_busy  in  1  encoder-decoder padding in progress; no input beat may be presented
- edc_start  out  1  start pulse to BCEDN_ENDECODER
- in_en  out  1  input beat valid
- data_in  out  D  input pixel vector; 0 when in_en=0
- out_en  in  1  encoder-decoder output beat
- busy  out  1  high from accepted go until done
- done  out  1  1-cycle pulse when N_OUT beats have been seen
- timeout  out  1  sticky error flag; present only with the optional feature, tied 0 otherwise

Behaviour:

Reset (rst=0 at a clk edge):
- State returns to IDLE; all counters clear.
- Outputs go to 0: mem_rd, mem_addr, edc_start, in_en, data_in, busy, done, timeout.
- Reset mid-frame aborts the frame; the in-flight read is discarded.

State machine:
- IDLE
  - go=1 → START.
  - busy goes high the next cycle.
- START
  - edc_start=1 for exactly one cycle, then → FEED.
- FEED
  - mem_rd=1 when pad_busy=0 and the hold register will be free next cycle; otherwise mem_rd=0.
  - col increments per issued read.
  - At col=W-1: col wraps to 0 and row increments.
    - If P>0 → GAP.
    - If the last row has been issued → DRAIN.
- GAP
  - P cycles with mem_rd=0, then → FEED.
  - After the last row, go directly to DRAIN with no gap.
- DRAIN
  - Wait until the in-flight/held beat is delivered and out_cnt=N_OUT.
  - Then → DONE.
- DONE
  - done=1 for one cycle, busy falls, → IDLE.

Input datapath:
- Read data returning 1 cycle after mem_rd is presented on the stream.
- Delivery: in_en = valid_q & ~pad_busy, combinational in pad_busy. The padding stall from the edc controller is combinational.
- If pad_busy=1 when data returns, the beat goes to a single hold register. It is presented on the first cycle with pad_busy=0.
- No new read is issued while the hold register is full.
- Beats leave in raster order; none are duplicated or dropped.
- Exactly H*W beats with in_en=1 per frame.
- data_in is 0 whenever in_en=0.

Output counting:
- out_cnt increments on each out_en=1, in any state after START.
- out_en beats beyond N_OUT are ignored.
- out_en in IDLE is ignored.

Simultaneous and boundary events:
- go while busy: ignored.
- pad_busy rising in the same cycle as the data return: the beat is held, not lost.
- out_en reaching N_OUT before all input is fed (should not occur): DONE still waits for all H*W inputs.
- mem_addr holds its last value when mem_rd=0.

Optional Feature:
- Macro: BCEDN_SCHED_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles in DRAIN since the last out_en.
  - On reaching TIMEOUT_CYC, timeout is set (sticky until reset or the next accepted go) and the FSM goes to DONE, pulsing done.
- When not defined:
  - No watchdog logic is built; timeout is tied to 0.
  - DRAIN waits indefinitely.

Decomposition:
- Package bcedn_sched_pkg holds:
  - the state enum (IDLE, START, FEED, GAP, DRAIN, DONE);
  - localparam helpers for counter widths: ROW_W, COL_W, GAP_W, OUT_W (computed with clog2).
- One natural sub-module: bcedn_sched_skid, the 1-entry hold register with valid/pad_busy handling, instantiated once.

Test Plan:
- Basic frame: H=2, W=3, P=0, N_OUT=6, pad_busy=0, mem_rdata=addr.
  - edc_start 1 cycle after go.
  - in_en beats carry 0..5 on consecutive cycles.
  - done after the 6th out_en; busy then low.
- Row gap: H=2, W=3, P=2 → exactly 2 idle in_en cycles between beat 2 and beat 3; no gap after the last row.
- Stall: pad_busy=1 for 3 cycles, coinciding with a data return of value 4.
  - in_en=0 during the stall.
  - Value 4 is delivered on the first cycle after pad_busy falls.
  - Order is intact; no duplicates.
- Go ignored and reset abort: go pulsed mid-frame → no effect. rst=0 mid-FEED → all outputs 0 next cycle; a new go restarts from addr 0.
- Watchdog (macro defined, TIMEOUT_CYC=16): withhold out_en after input completes → timeout=1 and done pulse 16 cycles after the last out_en. Without the macro, busy stays high.
